// File: rtl/mem_ctrl.sv
// Purpose: LC-3 memory port sequencer. Owns MAR/MDR, runs one SRAM or
// memory-mapped I/O access per request with WAIT_CYCLES wait states, and
// raises rdy (R) for exactly one cycle when the access completes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus_in, ld_mar, ld_mdr        processor bus and MAR/MDR load enables
//   mio_en, rw                    access request, 1 = write / 0 = read
//   rdy, mdr                      access complete, MDR contents
//   sram_*                        synchronous SRAM port (1-cycle read latency)
//   kb_valid/kb_data/kb_ready/kb_int        keyboard handshake and interrupt
//   disp_valid/disp_data/disp_ack           display handshake
//   mcr_run                       MCR[15]
module mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] MCR_RESET   = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        rw,
    output logic        rdy,
    output logic [15:0] mdr,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_re,
    output logic        sram_we,
    input  logic [15:0] sram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        kb_int,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack,
    output logic        mcr_run
);

    localparam int unsigned CW = 4;
    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [15:0]     mar, acc_addr, mcr;
    logic            acc_rw;
    logic            start, rdy_d, re_d, we_d;
    logic            kbsr_rdy, kbsr_ie, kbsr_rdy_d, kbsr_ie_d;
    logic [7:0]      kbdr;
    logic            is_mmio, mmio_rd, mmio_wr, kb_clear, kb_accept;
    logic            ddr_wr, done_load;
    logic [15:0]     mmio_rdata, rd_data;

    // Next state and next values of the registered strobes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        start   = 1'b0;
        rdy_d   = 1'b0;
        re_d    = 1'b0;
        we_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mio_en) begin
                    state_d = S_ACCESS;
                    start   = 1'b1;
                    cnt_d   = CW'(WAIT_CYCLES);
                    // Strobes are registered so they appear during ACCESS.
                    if (mar < MMIO_BASE) begin
                        re_d = !rw;
                        we_d = rw;
                    end
                end
            end
            S_ACCESS: begin
                if (!mio_en) begin
                    state_d = S_IDLE;
                end else if (cnt == CW'(0)) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt - CW'(1);
                if (!mio_en) begin
                    state_d = S_IDLE;
                end else if (cnt == CW'(1)) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MMIO decode, read mux and keyboard status update; effects only in DONE.
    always_comb begin
        is_mmio = (acc_addr >= MMIO_BASE);
        mmio_rd = (state == S_DONE) && is_mmio && !acc_rw;
        mmio_wr = (state == S_DONE) && is_mmio && acc_rw;
        case (acc_addr)
            ADDR_KBSR: mmio_rdata = {kbsr_rdy, kbsr_ie, 14'b0};
            ADDR_KBDR: mmio_rdata = {8'b0, kbdr};
            ADDR_DSR:  mmio_rdata = {!disp_valid, 15'b0};
            ADDR_MCR:  mmio_rdata = mcr;
            default:   mmio_rdata = 16'h0000;
        endcase
        rd_data    = is_mmio ? mmio_rdata : sram_rdata;
        done_load  = (state == S_DONE) && !acc_rw && ld_mdr;
        ddr_wr     = mmio_wr && (acc_addr == ADDR_DDR) && !disp_valid;
        kb_clear   = mmio_rd && (acc_addr == ADDR_KBDR);
        // A KBDR read clearing the status blocks a same-cycle acceptance.
        kb_accept  = kb_valid && kb_ready && !kb_clear;
        kbsr_rdy_d = kb_clear ? 1'b0 : (kb_accept ? 1'b1 : kbsr_rdy);
        kbsr_ie_d  = (mmio_wr && (acc_addr == ADDR_KBSR)) ? mdr[14] : kbsr_ie;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mar        <= '0;
            mdr        <= '0;
            acc_addr   <= '0;
            acc_rw     <= 1'b0;
            rdy        <= 1'b0;
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            kbsr_rdy   <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= '0;
            kb_ready   <= 1'b1;
            kb_int     <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            mcr        <= MCR_RESET;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rdy      <= rdy_d;
            sram_re  <= re_d;
            sram_we  <= we_d;
            kbsr_rdy <= kbsr_rdy_d;
            kbsr_ie  <= kbsr_ie_d;
            kb_ready <= !kbsr_rdy_d;
            kb_int   <= kbsr_rdy_d && kbsr_ie_d;
            if (ld_mar) begin
                mar <= bus_in;
            end
            if (done_load) begin
                mdr <= rd_data;
            end else if (ld_mdr && !mio_en) begin
                mdr <= bus_in;
            end
            if (start) begin
                acc_addr   <= mar;
                acc_rw     <= rw;
                sram_addr  <= mar;
                sram_wdata <= mdr;
            end
            if (kb_accept) begin
                kbdr <= kb_data;
            end
            if (ddr_wr) begin
                disp_valid <= 1'b1;
                disp_data  <= mdr[7:0];
            end else if (disp_valid && disp_ack) begin
                disp_valid <= 1'b0;
            end
            if (mmio_wr && (acc_addr == ADDR_MCR)) begin
                mcr <= mdr;
            end
        end
    end

    assign mcr_run = mcr[15];

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous SRAM.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, rw;
    logic        rdy;
    logic [15:0] mdr, sram_addr, sram_wdata;
    logic        sram_re, sram_we;
    logic [15:0] sram_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready, kb_int, disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ack, mcr_run;

    int errors = 0;
    int checks = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    logic [15:0] last_we_addr, last_we_data;
    logic [15:0] mem [0:65535];

    mem_ctrl #(.WAIT_CYCLES(2), .MCR_RESET(16'h8000)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .rw(rw), .rdy(rdy), .mdr(mdr), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_re(sram_re), .sram_we(sram_we),
        .sram_rdata(sram_rdata), .kb_valid(kb_valid), .kb_data(kb_data),
        .kb_ready(kb_ready), .kb_int(kb_int), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_ack(disp_ack), .mcr_run(mcr_run)
    );

    always #5 clk = ~clk;

    // SRAM model: read data valid the cycle after sram_re and held.
    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            last_we_addr   <= sram_addr;
            last_we_data   <= sram_wdata;
            we_cnt         <= we_cnt + 1;
        end
        if (sram_re) begin
            sram_rdata <= mem[sram_addr];
            re_cnt     <= re_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full access: load MAR (and MDR for writes), hold mio_en until rdy.
    task automatic do_access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                             output int first, output int nrdy);
        bus_in = addr; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
        if (wr) begin
            bus_in = wdata; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
        end
        bus_in = 16'h0; rw = wr; mio_en = 1'b1; ld_mdr = !wr;
        first = -1; nrdy = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (first >= 0 && c == first + 1) ld_mdr = 1'b0;
            if (rdy) begin
                nrdy++;
                if (first < 0) begin
                    first  = c;
                    mio_en = 1'b0;
                end
            end
        end
        mio_en = 1'b0; ld_mdr = 1'b0; rw = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, nrdy, re0, we0;
        mem[16'h3000] = 16'h1234;
        rst = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0;
        kb_valid = 0; kb_data = '0; disp_ack = 0;
        tick(); tick();
        rst = 1'b0;

        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_mdr", 32'(mdr), 32'h0);
        check("rst_kb_ready", 32'(kb_ready), 32'd1);
        check("rst_mcr_run", 32'(mcr_run), 32'd1);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_sram_re", 32'(sram_re), 32'd0);

        // SRAM read
        re0 = re_cnt;
        do_access(16'h3000, 1'b0, 16'h0, first, nrdy);
        check("rd_rdy_cycle", 32'(first), 32'd4);
        check("rd_rdy_count", 32'(nrdy), 32'd1);
        check("rd_mdr", 32'(mdr), 32'h1234);
        check("rd_re_count", 32'(re_cnt - re0), 32'd1);

        // SRAM write
        we0 = we_cnt;
        do_access(16'h4000, 1'b1, 16'hBEEF, first, nrdy);
        check("wr_rdy_cycle", 32'(first), 32'd4);
        check("wr_we_count", 32'(we_cnt - we0), 32'd1);
        check("wr_addr", 32'(last_we_addr), 32'h4000);
        check("wr_data", 32'(last_we_data), 32'hBEEF);

        // Keyboard
        kb_valid = 1'b1; kb_data = 8'h41; tick(); kb_valid = 1'b0;
        check("kb_ready_low", 32'(kb_ready), 32'd0);
        re0 = re_cnt;
        do_access(16'hFE00, 1'b0, 16'h0, first, nrdy);
        check("kbsr_full", 32'(mdr), 32'h8000);
        do_access(16'hFE02, 1'b0, 16'h0, first, nrdy);
        check("kbdr", 32'(mdr), 32'h0041);
        check("kbdr_rdy_cycle", 32'(first), 32'd4);
        do_access(16'hFE00, 1'b0, 16'h0, first, nrdy);
        check("kbsr_empty", 32'(mdr), 32'h0000);
        check("kb_ready_high", 32'(kb_ready), 32'd1);
        check("mmio_no_re", 32'(re_cnt - re0), 32'd0);

        // Display
        do_access(16'hFE06, 1'b1, 16'h0058, first, nrdy);
        check("ddr_valid", 32'(disp_valid), 32'd1);
        check("ddr_data", 32'(disp_data), 32'h58);
        do_access(16'hFE04, 1'b0, 16'h0, first, nrdy);
        check("dsr_busy", 32'(mdr), 32'h0000);
        do_access(16'hFE06, 1'b1, 16'h0059, first, nrdy);
        check("ddr_drop", 32'(disp_data), 32'h58);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        check("ddr_ack", 32'(disp_valid), 32'd0);
        do_access(16'hFE04, 1'b0, 16'h0, first, nrdy);
        check("dsr_ready", 32'(mdr), 32'h8000);

        // Abort during WAIT
        bus_in = 16'h3000; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
        mio_en = 1'b1; rw = 1'b0;
        nrdy = 0;
        tick(); tick();
        mio_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rdy) nrdy++;
        end
        check("abort_no_rdy", 32'(nrdy), 32'd0);
        do_access(16'h3000, 1'b0, 16'h0, first, nrdy);
        check("after_abort_cycle", 32'(first), 32'd4);

        // MCR write, then reset mid-access
        do_access(16'hFFFE, 1'b1, 16'h0000, first, nrdy);
        check("mcr_run_off", 32'(mcr_run), 32'd0);
        bus_in = 16'h3000; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
        mio_en = 1'b1; tick(); tick();
        rst = 1'b1; mio_en = 1'b0; tick(); rst = 1'b0;
        check("mid_rst_rdy", 32'(rdy), 32'd0);
        check("mid_rst_mdr", 32'(mdr), 32'h0);
        check("mid_rst_mcr_run", 32'(mcr_run), 32'd1);
        check("mid_rst_kb_ready", 32'(kb_ready), 32'd1);
        check("mid_rst_sram_re", 32'(sram_re), 32'd0);
        do_access(16'h3000, 1'b0, 16'h0, first, nrdy);
        check("post_rst_cycle", 32'(first), 32'd4);
        check("post_rst_mdr", 32'(mdr), 32'h1234);

        // Keyboard interrupt enable with a pending char
        kb_valid = 1'b1; kb_data = 8'h42; tick(); kb_valid = 1'b0;
        check("kb_int_off", 32'(kb_int), 32'd0);
        do_access(16'hFE00, 1'b1, 16'h4000, first, nrdy);
        check("kb_int_on", 32'(kb_int), 32'd1);
        do_access(16'hFE00, 1'b0, 16'h0, first, nrdy);
        check("kbsr_ie", 32'(mdr), 32'hC000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
